// File: rtl/pixel_line_fetch.sv
// Scanline prefetcher: on line_start it streams sequential pixel reads from line_base
// into a small FIFO, limiting outstanding reads so returns never overflow the FIFO.
module pixel_line_fetch #(
  parameter int ADDR_W      = 9,
  parameter int PIX_W       = 4,
  parameter int DEPTH       = 8,
  parameter int MEM_LAT     = 2,
  parameter int LINE_PIXELS = 160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic              bank_sel,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_bank,
  output logic              mem_read,
  input  logic              pix_pop,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic              fetch_busy,
  output logic              underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(LINE_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [RW-1:0]       remaining, remaining_n;
  logic [CW-1:0]       count, count_n;
  logic [CW-1:0]       inflight, inflight_n;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [MEM_LAT-1:0]  vpipe;
  logic [PIX_W-1:0]    fifo [DEPTH];
  logic                push, pop, issue_n;

  assign pix_valid  = (count != '0);
  assign pix_out    = pix_valid ? fifo[rd_ptr] : '0;
  assign fetch_busy = (state != IDLE);

  // mem_read is registered, so the issue decision is made on next-cycle values:
  // the read strobe then lands in the very cycle its credit was granted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    push        = vpipe[MEM_LAT-1] && !line_start;
    pop         = pix_pop && pix_valid && !line_start;
    count_n     = count + CW'(push) - CW'(pop);
    inflight_n  = inflight + CW'(mem_read) - CW'(push);
    remaining_n = remaining - RW'(mem_read);
    addr_n      = addr + ADDR_W'(mem_read);
    state_n     = state;

    case (state)
      FETCH:   if (remaining_n == '0) state_n = DRAIN;
      DRAIN:   if (inflight == '0)    state_n = IDLE;
      default: state_n = state;
    endcase

    if (line_start) begin
      count_n     = '0;
      inflight_n  = '0;
      remaining_n = RW'(LINE_PIXELS);
      addr_n      = line_base;
      state_n     = FETCH;
    end

    issue_n = (state_n == FETCH) && (remaining_n != '0) &&
              ((SW'(count_n) + SW'(inflight_n)) < SW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      count     <= '0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      vpipe     <= '0;
      mem_addr  <= '0;
      mem_bank  <= 1'b0;
      mem_read  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      addr      <= addr_n;
      remaining <= remaining_n;
      count     <= count_n;
      inflight  <= inflight_n;
      mem_read  <= issue_n;
      if (issue_n) mem_addr <= addr_n;
      // Clearing the tracker on line_start drops returns that belong to the old line.
      vpipe     <= line_start ? '0 : ((vpipe << 1) | MEM_LAT'(mem_read));
      if (line_start) begin
        mem_bank <= bank_sel;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (pix_pop && !pix_valid) underflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; count gates every read so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= pixel_in;
  end

endmodule

// File: tb/tb_pixel_line_fetch.sv
// Randomized bench for pixel_line_fetch: a fixed-latency memory model plus a line-level
// reference (reads issued, pixels popped, credit limit) checked every cycle.
module tb_pixel_line_fetch;

  localparam int ADDR_W      = 9;
  localparam int PIX_W       = 4;
  localparam int DEPTH       = 8;
  localparam int MEM_LAT     = 2;
  localparam int LINE_PIXELS = 160;
  localparam int TIMEOUT     = 3000;

  typedef enum {POP_NONE, POP_VALID, POP_RAND, POP_FORCE} pop_mode_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              line_start;
  logic [ADDR_W-1:0] line_base;
  logic              bank_sel;
  logic [PIX_W-1:0]  pixel_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_bank;
  logic              mem_read;
  logic              pix_pop;
  logic [PIX_W-1:0]  pix_out;
  logic              pix_valid;
  logic              fetch_busy;
  logic              underflow;

  int checks   = 0;
  int failures = 0;

  pixel_line_fetch #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH),
    .MEM_LAT(MEM_LAT), .LINE_PIXELS(LINE_PIXELS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_base(line_base),
    .bank_sel(bank_sel), .pixel_in(pixel_in), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_read(mem_read), .pix_pop(pix_pop), .pix_out(pix_out), .pix_valid(pix_valid),
    .fetch_busy(fetch_busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] pix_of(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] s);
    return a[PIX_W-1:0] ^ s;
  endfunction

  // Memory: data = addr[3:0] ^ salt, returned MEM_LAT cycles after the read strobe.
  logic [PIX_W-1:0]  salt = '0;
  logic [ADDR_W:0]   lat_q [MEM_LAT] = '{default: '0};

  always @(posedge clk) begin
    lat_q[0] <= {mem_read, mem_addr};
    for (int i = 1; i < MEM_LAT; i++) lat_q[i] <= lat_q[i-1];
  end

  assign pixel_in = lat_q[MEM_LAT-1][PIX_W-1:0] ^ salt ^ {PIX_W{~lat_q[MEM_LAT-1][ADDR_W]}};

  // Consumer
  pop_mode_t pop_mode   = POP_NONE;
  int        pop_budget = 0;

  always @(posedge clk) begin
    #1;
    case (pop_mode)
      POP_VALID: begin
        pix_pop = pix_valid && (pop_budget > 0);
        if (pix_pop) pop_budget--;
      end
      POP_RAND:  pix_pop = pix_valid && ($urandom_range(0, 3) != 0);
      POP_FORCE: pix_pop = 1'b1;
      default:   pix_pop = 1'b0;
    endcase
  end

  // Reference: per line, read k goes to base+k and is poppable MEM_LAT+1 cycles after
  // its strobe; a read is issued whenever reads-pops < DEPTH and the line is unfinished.
  int                now = 0;
  int                reads = 0;
  int                pops = 0;
  int                last_issue = 0;
  int                issue_t[$];
  logic [ADDR_W-1:0] base = '0;
  logic              bank_e = 1'b0;
  logic [PIX_W-1:0]  line_salt = '0;
  bit                line_active = 1'b0;
  bit                uf_exp = 1'b0;

  always @(negedge clk) begin : monitor
    int               avail;
    bit               exp_rd, exp_valid, exp_busy;
    logic [PIX_W-1:0] exp_pix;
    logic [ADDR_W-1:0] exp_addr;
    if (!rst_n) begin
      line_active = 1'b0;
      uf_exp      = 1'b0;
      reads       = 0;
      pops        = 0;
      issue_t.delete();
    end else begin
      avail = 0;
      foreach (issue_t[i]) if (issue_t[i] + MEM_LAT + 1 <= now) avail++;
      exp_valid = (avail > pops);
      exp_addr  = base + ADDR_W'(pops);
      exp_pix   = exp_valid ? pix_of(exp_addr, line_salt) : '0;
      exp_rd    = line_active && (reads < LINE_PIXELS) && (reads - pops < DEPTH);
      exp_busy  = line_active && !(reads == LINE_PIXELS && now >= last_issue + MEM_LAT + 2);
      check("mem_read", mem_read, exp_rd);
      check("pix_valid", pix_valid, exp_valid);
      check("pix_out", pix_out, exp_pix);
      check("fetch_busy", fetch_busy, exp_busy);
      check("underflow", underflow, uf_exp);
      if (mem_read) begin
        exp_addr = base + ADDR_W'(reads);
        check("mem_addr", mem_addr, exp_addr);
        check("mem_bank", mem_bank, bank_e);
        issue_t.push_back(now);
        last_issue = now;
        reads++;
        check("fifo_no_overflow", (reads - pops) <= DEPTH, 1);
      end
      if (line_start) begin
        base        = line_base;
        bank_e      = bank_sel;
        line_salt   = salt;
        reads       = 0;
        pops        = 0;
        line_active = 1'b1;
        issue_t.delete();
      end else if (pix_pop) begin
        if (exp_valid) pops++;
        else uf_exp = 1'b1;
      end
    end
    now++;
  end

  task automatic start_line(input logic [ADDR_W-1:0] b, input logic bk, input logic [PIX_W-1:0] s);
    @(posedge clk); #1;
    salt       = s;
    line_start = 1'b1;
    line_base  = b;
    bank_sel   = bk;
    @(posedge clk); #1;
    line_start = 1'b0;
    line_base  = ADDR_W'($urandom);
    bank_sel   = 1'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(reads == LINE_PIXELS && pops == LINE_PIXELS && !fetch_busy) && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n < TIMEOUT, 1);
    check("line_read_total", reads, LINE_PIXELS);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_bank"}, mem_bank, 0);
    check({tag, "_mem_read"}, mem_read, 0);
    check({tag, "_pix_out"}, pix_out, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_fetch_busy"}, fetch_busy, 0);
    check({tag, "_underflow"}, underflow, 0);
  endtask

  initial begin
    int lat;
    int n;
    rst_n      = 1'b0;
    line_start = 1'b0;
    line_base  = '0;
    bank_sel   = 1'b0;
    pix_pop    = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Full line from base 0: data is addr[3:0], consumer pops from the first valid pixel.
    pop_budget = 1 << 30;
    pop_mode   = POP_VALID;
    start_line(9'h000, 1'b1, 4'h0);
    lat = 1;
    while (!pix_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first_valid_latency", lat, MEM_LAT + 2);
    check("first_pixel", pix_out, 0);
    wait_done("main_line_timeout");
    check("main_underflow", underflow, 0);

    // Credit limit: no pops fills exactly DEPTH, then three pops allow three more reads.
    pop_mode = POP_NONE;
    start_line(ADDR_W'($urandom), 1'b0, PIX_W'($urandom));
    repeat (30) @(posedge clk);
    #1;
    check("credit_reads_full", reads, DEPTH);
    check("credit_fifo_full", pix_valid, 1);
    pop_budget = 3;
    pop_mode   = POP_VALID;
    repeat (30) @(posedge clk);
    #1;
    check("credit_refill_reads", reads, DEPTH + 3);
    pop_mode = POP_RAND;
    wait_done("credit_line_timeout");

    // Address wrap past the top of memory.
    start_line(9'h1FE, 1'b1, PIX_W'($urandom));
    wait_done("wrap_line_timeout");

    // Restart with reads in flight and pixels buffered.
    pop_mode = POP_NONE;
    start_line(ADDR_W'($urandom), 1'b0, PIX_W'($urandom));
    n = 0;
    while (reads < 7 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart_wait", n < 100, 1);
    start_line(ADDR_W'($urandom), 1'b1, PIX_W'($urandom));
    check("restart_flush", pix_valid, 0);
    pop_mode = POP_RAND;
    wait_done("restart_line_timeout");

    // Random lines, some interrupted mid-fetch.
    for (int i = 0; i < 3; i++) begin
      start_line(ADDR_W'($urandom), 1'($urandom), PIX_W'($urandom));
      repeat ($urandom_range(0, 120)) @(posedge clk);
      start_line(ADDR_W'($urandom), 1'($urandom), PIX_W'($urandom));
      wait_done("random_line_timeout");
    end

    // Asynchronous reset in the middle of a fetch.
    start_line(ADDR_W'($urandom), 1'b1, PIX_W'($urandom));
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midfetch_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle", fetch_busy, 0);

    // Pop while empty before any line_start: sticky until reset.
    pop_mode = POP_FORCE;
    repeat (2) @(posedge clk);
    pop_mode = POP_NONE;
    repeat (2) @(posedge clk);
    #1;
    check("underflow_set", underflow, 1);
    pop_mode = POP_RAND;
    start_line(ADDR_W'($urandom), 1'b0, PIX_W'($urandom));
    wait_done("underflow_line_timeout");
    start_line(ADDR_W'($urandom), 1'b1, PIX_W'($urandom));
    repeat (5) @(posedge clk);
    #1;
    check("underflow_sticky", underflow, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("final_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
